// File: rtl/mealy_seq_detector.sv
// Parametrised Mealy serial-pattern detector.
// One serial bit is consumed per enabled clock. z rises in the same cycle as
// the bit that completes the pattern. The pattern can be reloaded at runtime,
// overlapping matches are optional, and a saturating counter tracks matches.
module mealy_seq_detector #(
   parameter int                 PAT_LEN = 4,
   parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
   parameter int                 CNT_W   = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic               P1,
   input  logic               overlap,
   input  logic               pat_we,
   input  logic [PAT_LEN-1:0] pat_in,
   output logic               z,
   output logic [CNT_W-1:0]   match_cnt,
   output logic               cnt_sat
);

   localparam int                 FW       = $clog2(PAT_LEN);
   localparam logic [FW-1:0]      FILL_MAX = FW'(PAT_LEN - 1);
   localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
   localparam logic [CNT_W-1:0]   CNT_PRE  = CNT_MAX - 1'b1;

   logic [PAT_LEN-2:0] hist;
   logic [FW-1:0]      fill;
   logic [PAT_LEN-1:0] pat;
   logic [PAT_LEN-1:0] window;
   logic               full;
   logic               hit;

   // The candidate window is the stored history with the incoming bit as the
   // newest (LSB) position. A match needs a full history, so the zeroed
   // history left by reset can never match a pattern such as all-zeros.
   assign window = {hist, P1};
   assign full   = (fill == FILL_MAX);
   assign hit    = en & ~pat_we & full & (window == pat);
   assign z      = hit & ~reset;

   // History, fill level, pattern and match counter. Reset beats pattern load,
   // which beats normal sampling.
   always_ff @(posedge clk) begin
      if (reset) begin
         hist      <= '0;
         fill      <= '0;
         pat       <= PATTERN;
         match_cnt <= '0;
         cnt_sat   <= 1'b0;
      end else if (pat_we) begin
         pat       <= pat_in;
         hist      <= '0;
         fill      <= '0;
         match_cnt <= '0;
         cnt_sat   <= 1'b0;
      end else if (en) begin
         if (hit && !overlap) begin
            hist <= '0;
            fill <= '0;
         end else begin
            hist <= window[PAT_LEN-2:0];
            if (!full) begin
               fill <= fill + 1'b1;
            end
         end
         if (hit && (match_cnt != CNT_MAX)) begin
            match_cnt <= match_cnt + 1'b1;
            if (match_cnt == CNT_PRE) begin
               cnt_sat <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_mealy_seq_detector.sv
// Testbench for mealy_seq_detector: directed vectors with hand-computed z and
// counter values, plus a queue-based model compared against two instances
// (8-bit and 2-bit counters) on every cycle.
module tb_mealy_seq_detector;

   localparam int         PAT_LEN = 4;
   localparam logic [3:0] PATTERN = 4'b1101;

   logic       clk;
   logic       reset;
   logic       en;
   logic       P1;
   logic       overlap;
   logic       pat_we;
   logic [3:0] pat_in;
   logic       z8;
   logic       z2;
   logic [7:0] cnt8;
   logic [1:0] cnt2;
   logic       sat8;
   logic       sat2;

   int total = 0;
   int bad   = 0;
   bit checking = 1'b0;

   bit         hq[$];
   logic [3:0] mpat = PATTERN;
   int         mcnt8 = 0;
   int         mcnt2 = 0;

   mealy_seq_detector #(.PAT_LEN(PAT_LEN), .PATTERN(PATTERN), .CNT_W(8)) dut8 (
      .clk(clk), .reset(reset), .en(en), .P1(P1), .overlap(overlap),
      .pat_we(pat_we), .pat_in(pat_in), .z(z8), .match_cnt(cnt8), .cnt_sat(sat8)
   );

   mealy_seq_detector #(.PAT_LEN(PAT_LEN), .PATTERN(PATTERN), .CNT_W(2)) dut2 (
      .clk(clk), .reset(reset), .en(en), .P1(P1), .overlap(overlap),
      .pat_we(pat_we), .pat_in(pat_in), .z(z2), .match_cnt(cnt2), .cnt_sat(sat2)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   // Model: a match happens when the last PAT_LEN-1 accepted bits followed by
   // the current bit spell the pattern, MSB first.
   function automatic logic modelZ();
      if (reset || !en || pat_we || hq.size() != PAT_LEN - 1) return 1'b0;
      for (int i = 0; i < PAT_LEN - 1; i++) begin
         if (hq[i] != mpat[PAT_LEN-1-i]) return 1'b0;
      end
      return (P1 == mpat[0]);
   endfunction

   function automatic void modelStep();
      if (reset) begin
         hq.delete();
         mpat  = PATTERN;
         mcnt8 = 0;
         mcnt2 = 0;
      end else if (pat_we) begin
         hq.delete();
         mpat  = pat_in;
         mcnt8 = 0;
         mcnt2 = 0;
      end else if (en) begin
         logic m;
         m = modelZ();
         hq.push_back(P1);
         if (hq.size() > PAT_LEN - 1) void'(hq.pop_front());
         if (m) begin
            if (mcnt8 < 255) mcnt8++;
            if (mcnt2 < 3) mcnt2++;
            if (!overlap) hq.delete();
         end
      end
   endfunction

   // Drive one cycle at the falling edge, pin z to a literal, then advance the
   // model at the rising edge with the same inputs.
   task automatic applyStimulus(input string nm, input logic r, input logic e,
                                input logic p, input logic o, input logic w,
                                input logic [3:0] pin, input logic ez);
      @(negedge clk);
      reset   = r;
      en      = e;
      P1      = p;
      overlap = o;
      pat_we  = w;
      pat_in  = pin;
      #1;
      checkOutput({nm, "_z8"}, int'(z8), int'(ez));
      checkOutput({nm, "_z2"}, int'(z2), int'(ez));
      @(posedge clk);
      modelStep();
   endtask

   task automatic feed(input string nm, input string bits, input string zs, input logic o);
      for (int i = 0; i < bits.len(); i++) begin
         applyStimulus($sformatf("%s[%0d]", nm, i), 1'b0, 1'b1, bits[i] == "1", o,
                       1'b0, 4'b0000, zs[i] == "1");
      end
   endtask

   task automatic expectCnt(input string nm, input int c8, input int c2, input int s2);
      #1;
      checkOutput({nm, "_cnt8"}, int'(cnt8), c8);
      checkOutput({nm, "_sat8"}, int'(sat8), 0);
      checkOutput({nm, "_cnt2"}, int'(cnt2), c2);
      checkOutput({nm, "_sat2"}, int'(sat2), s2);
   endtask

   // Compare both instances against the model every cycle, after inputs settle.
   always @(negedge clk) begin
      #2;
      if (checking) begin
         checkOutput("model_z8",   int'(z8),   int'(modelZ()));
         checkOutput("model_z2",   int'(z2),   int'(modelZ()));
         checkOutput("model_cnt8", int'(cnt8), mcnt8);
         checkOutput("model_sat8", int'(sat8), int'(mcnt8 == 255));
         checkOutput("model_cnt2", int'(cnt2), mcnt2);
         checkOutput("model_sat2", int'(sat2), int'(mcnt2 == 3));
      end
   end

   // Guard against a stalled run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenario sequence.
   initial begin
      reset = 1'b1; en = 1'b0; P1 = 1'b0; overlap = 1'b1; pat_we = 1'b0; pat_in = 4'b0000;

      applyStimulus("rst0", 1, 1, 1, 1, 0, 4'b0000, 0);
      checking = 1'b1;
      applyStimulus("rst1", 1, 1, 1, 1, 0, 4'b0000, 0);
      expectCnt("after_reset", 0, 0, 0);

      feed("basic", "1101", "0001", 1);
      expectCnt("basic", 1, 1, 0);
      feed("ovl_on", "101", "001", 1);
      expectCnt("ovl_on", 2, 2, 0);

      applyStimulus("rst2", 1, 0, 0, 1, 0, 4'b0000, 0);
      feed("ovl_off", "1101101", "0001000", 0);
      expectCnt("ovl_off", 1, 1, 0);

      applyStimulus("rst3", 1, 0, 0, 1, 0, 4'b0000, 0);
      feed("gate_a", "11", "00", 1);
      applyStimulus("gate_skip", 0, 0, 0, 1, 0, 4'b0000, 0);
      feed("gate_b", "110", "000", 1);
      applyStimulus("gate_hold", 0, 0, 1, 1, 0, 4'b0000, 0);
      feed("gate_c", "1", "1", 1);
      expectCnt("gate", 1, 1, 0);

      applyStimulus("load0", 0, 1, 0, 1, 1, 4'b0000, 0);
      expectCnt("load0", 0, 0, 0);
      feed("zero", "00000", "00011", 1);
      expectCnt("zero", 2, 2, 0);

      applyStimulus("load1010", 0, 1, 1, 1, 1, 4'b1010, 0);
      expectCnt("load1010", 0, 0, 0);
      feed("p1010", "1010", "0001", 1);
      expectCnt("p1010", 1, 1, 0);
      feed("p1010b", "1", "0", 1);
      applyStimulus("load_block", 0, 1, 0, 1, 1, 4'b1010, 0);
      expectCnt("load_block", 0, 0, 0);
      feed("p1010c", "010", "000", 1);

      applyStimulus("rst4", 1, 0, 0, 1, 0, 4'b0000, 0);
      feed("rp_a", "1101", "0001", 1);
      feed("rp_b", "10", "00", 1);
      applyStimulus("rst_hit", 1, 1, 1, 1, 1, 4'b0000, 0);
      expectCnt("rst_hit", 0, 0, 0);
      feed("rp_c", "1", "0", 1);
      feed("rp_d", "101", "001", 1);
      expectCnt("rp_d", 1, 1, 0);

      applyStimulus("load_sat", 0, 0, 0, 1, 1, 4'b1101, 0);
      feed("sat1", "1101", "0001", 1);
      expectCnt("sat1", 1, 1, 0);
      for (int k = 2; k <= 5; k++) begin
         feed($sformatf("sat%0d", k), "101", "001", 1);
         expectCnt($sformatf("sat%0d", k), k, (k > 3) ? 3 : k, (k >= 3) ? 1 : 0);
      end
      applyStimulus("load_clr", 0, 0, 0, 1, 1, 4'b1101, 0);
      expectCnt("load_clr", 0, 0, 0);
      feed("resat", "1101101101", "0001001001", 1);
      expectCnt("resat", 3, 3, 1);
      applyStimulus("rst_clr", 1, 0, 0, 1, 0, 4'b0000, 0);
      expectCnt("rst_clr", 0, 0, 0);

      repeat (2) @(negedge clk);
      #3;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
